action_selector: RTL and testbench

- Epsilon-greedy action selector for the 5x5 maze Q-learning loop.
- Sits directly upstream of the state selector and produces the one-hot `next_action` consumed there.
- Per request: reads the four Q-values of the current state from the Q-table RAM, masks moves that would leave the grid, then chooses either the greedy (argmax) action or a pseudo-random legal action, as decided by an LFSR draw against epsilon.

---
 rtl/rl_pkg.sv | 46 ++++
 rtl/action_selector_lfsr16.sv | 27 ++
 rtl/action_selector.sv | 174 +++++++++++++++++
 tb/tb_action_selector.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/rl_pkg.sv
// Shared definitions for the maze Q-learning datapath: action encoding,
// grid geometry and the action-selector FSM states.
package rl_pkg;

    localparam int STATE_W     = 6;
    localparam int ACTION_W    = 4;
    localparam int GRID_DIM    = 5;
    localparam int NUM_STATES  = 25;
    localparam int GOAL_STATE  = 25;
    localparam int Q_W_DEFAULT = 16;

    localparam logic [1:0] ACT_UP    = 2'd0;
    localparam logic [1:0] ACT_DOWN  = 2'd1;
    localparam logic [1:0] ACT_LEFT  = 2'd2;
    localparam logic [1:0] ACT_RIGHT = 2'd3;

    typedef enum logic [2:0] {
        S_IDLE,
        S_READ,
        S_DRAIN,
        S_DECIDE,
        S_DONE
    } sel_state_e;

    function automatic logic [ACTION_W-1:0] onehot(input logic [1:0] idx);
        logic [ACTION_W-1:0] v;
        v      = '0;
        v[idx] = 1'b1;
        return v;
    endfunction

    function automatic logic state_ok(input logic [STATE_W-1:0] st);
        return (st >= 6'd1) && (st <= 6'd25);
    endfunction

    // Bit k set when action k keeps the agent inside the grid.
    function automatic logic [ACTION_W-1:0] legal_mask(input logic [STATE_W-1:0] st);
        logic [ACTION_W-1:0] m;
        m[ACT_UP]    = !(st <= 6'd5);
        m[ACT_DOWN]  = !(st >= 6'd21);
        m[ACT_LEFT]  = !(((st - 6'd1) % 6'd5) == 6'd0);
        m[ACT_RIGHT] = !((st % 6'd5) == 6'd0);
        return m;
    endfunction

endpackage

// File: rtl/action_selector_lfsr16.sv
// 16-bit Galois LFSR, x^16+x^14+x^13+x^11+1, stepping every cycle out of reset.
module lfsr16 #(
    parameter logic [15:0] SEED = 16'hACE1
) (
    input  logic        clk,
    input  logic        rst,
    output logic [15:0] q
);

    logic [15:0] q_q;
    logic [15:0] q_d;

    always_comb begin
        q_d = {1'b0, q_q[15:1]} ^ (q_q[0] ? 16'hB400 : 16'h0000);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q_q <= SEED;
        end else begin
            q_q <= q_d;
        end
    end

    assign q = q_q;

endmodule

// File: rtl/action_selector.sv
// Epsilon-greedy action selector: fetches the four Q-values of a cell,
// masks off-grid moves and picks the argmax or a random legal move.
module action_selector
    import rl_pkg::*;
#(
    parameter int          Q_W       = rl_pkg::Q_W_DEFAULT,
    parameter int          EPS_W     = 8,
    parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               en,
    input  logic               start,
    input  logic [EPS_W-1:0]   epsilon,
    input  logic [5:0]         current_state,
    output logic               q_rd_en,
    output logic [7:0]         q_addr,
    input  logic [Q_W-1:0]     q_rdata,
    output logic [3:0]         next_action,
    output logic               action_valid,
    output logic               explored,
    output logic               bad_state,
    output logic               busy
);

    logic [15:0] lfsr_q;
    logic        unused_lfsr;

    lfsr16 #(.SEED(LFSR_SEED)) u_lfsr (
        .clk (clk),
        .rst (rst),
        .q   (lfsr_q)
    );

    assign unused_lfsr = ^lfsr_q[15:10];

    sel_state_e              state_q, state_d;
    logic [STATE_W-1:0]      st_q, st_d;
    logic [1:0]              idx_q, idx_d;
    logic                    cap_en_q, cap_en_d;
    logic [1:0]              cap_idx_q, cap_idx_d;
    logic signed [Q_W-1:0]   qv_q [4];
    logic signed [Q_W-1:0]   qv_d [4];
    logic [ACTION_W-1:0]     next_action_q, next_action_d;
    logic                    explored_q, explored_d;
    logic                    bad_state_q, bad_state_d;

    logic [3:0]              legal;
    logic [1:0]              greedy_idx;
    logic [1:0]              rand_idx;
    logic [1:0]              cand;
    logic                    found;
    logic signed [Q_W-1:0]   best;
    logic                    explore;

    always_comb begin
        legal      = legal_mask(st_q);
        greedy_idx = ACT_UP;
        found      = 1'b0;
        best       = '0;
        for (int k = 0; k < 4; k++) begin
            if (legal[k] && (!found || (qv_q[k] > best))) begin
                found      = 1'b1;
                best       = qv_q[k];
                greedy_idx = 2'(k);
            end
        end
        // Walk offsets downward so the smallest legal offset is assigned last.
        rand_idx = lfsr_q[9:8];
        cand     = lfsr_q[9:8];
        for (int k = 3; k >= 0; k--) begin
            cand = lfsr_q[9:8] + 2'(k);
            if (legal[cand]) begin
                rand_idx = cand;
            end
        end
        explore = lfsr_q[EPS_W-1:0] < epsilon;
    end

    always_comb begin
        state_d       = state_q;
        st_d          = st_q;
        idx_d         = idx_q;
        cap_en_d      = 1'b0;
        cap_idx_d     = idx_q;
        next_action_d = next_action_q;
        explored_d    = explored_q;
        bad_state_d   = bad_state_q;
        for (int k = 0; k < 4; k++) begin
            qv_d[k] = qv_q[k];
        end
        // RAM data lags the strobe by one cycle, so capture trails the read.
        if (cap_en_q) begin
            qv_d[cap_idx_q] = q_rdata;
        end

        case (state_q)
            S_IDLE: begin
                if (start && en) begin
                    st_d = current_state;
                    if (state_ok(current_state)) begin
                        state_d = S_READ;
                        idx_d   = 2'd0;
                    end else begin
                        state_d       = S_DONE;
                        next_action_d = '0;
                        bad_state_d   = 1'b1;
                        explored_d    = 1'b0;
                    end
                end
            end
            S_READ: begin
                cap_en_d  = 1'b1;
                cap_idx_d = idx_q;
                idx_d     = idx_q + 2'd1;
                if (idx_q == 2'd3) begin
                    state_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
                state_d = S_DECIDE;
            end
            S_DECIDE: begin
                next_action_d = onehot(explore ? rand_idx : greedy_idx);
                explored_d    = explore;
                bad_state_d   = 1'b0;
                state_d       = S_DONE;
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= S_IDLE;
            st_q          <= '0;
            idx_q         <= '0;
            cap_en_q      <= 1'b0;
            cap_idx_q     <= '0;
            next_action_q <= '0;
            explored_q    <= 1'b0;
            bad_state_q   <= 1'b0;
            for (int k = 0; k < 4; k++) begin
                qv_q[k] <= '0;
            end
        end else begin
            state_q       <= state_d;
            st_q          <= st_d;
            idx_q         <= idx_d;
            cap_en_q      <= cap_en_d;
            cap_idx_q     <= cap_idx_d;
            next_action_q <= next_action_d;
            explored_q    <= explored_d;
            bad_state_q   <= bad_state_d;
            for (int k = 0; k < 4; k++) begin
                qv_q[k] <= qv_d[k];
            end
        end
    end

    assign q_rd_en      = (state_q == S_READ);
    assign q_addr       = (state_q == S_READ) ? {st_q, idx_q} : 8'd0;
    assign action_valid = (state_q == S_DONE);
    assign busy         = (state_q != S_IDLE);
    assign next_action  = next_action_q;
    assign explored     = explored_q;
    assign bad_state    = bad_state_q;

endmodule

// File: tb/tb_action_selector.sv
// Bench for action_selector: directed maze cases plus randomized requests
// checked against a row/column reference model and a free-running LFSR model.
module tb_action_selector;

    logic        clk;
    logic        rst;
    logic        en;
    logic        start;
    logic [7:0]  epsilon;
    logic [5:0]  current_state;
    logic        q_rd_en;
    logic [7:0]  q_addr;
    logic [15:0] q_rdata;
    logic [3:0]  next_action;
    logic        action_valid;
    logic        explored;
    logic        bad_state;
    logic        busy;

    int vectors;
    int miscompares;

    logic [15:0] qtab [4];
    logic [15:0] lfsr_m;

    action_selector #(.Q_W(16), .EPS_W(8), .LFSR_SEED(16'hACE1)) dut (
        .clk           (clk),
        .rst           (rst),
        .en            (en),
        .start         (start),
        .epsilon       (epsilon),
        .current_state (current_state),
        .q_rd_en       (q_rd_en),
        .q_addr        (q_addr),
        .q_rdata       (q_rdata),
        .next_action   (next_action),
        .action_valid  (action_valid),
        .explored      (explored),
        .bad_state     (bad_state),
        .busy          (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Q-table RAM with one cycle of read latency.
    always @(posedge clk) begin
        if (q_rd_en) q_rdata <= qtab[q_addr[1:0]];
    end

    // Feedback mask built from the polynomial exponents 16, 14, 13, 11.
    function automatic logic [15:0] m_step(input logic [15:0] s);
        logic [15:0] taps;
        taps = 16'((1 << (16 - 1)) | (1 << (14 - 1)) | (1 << (13 - 1)) | (1 << (11 - 1)));
        return s[0] ? ((s >> 1) ^ taps) : (s >> 1);
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) lfsr_m <= 16'hACE1;
        else     lfsr_m <= m_step(lfsr_m);
    end

    function automatic logic [3:0] m_legal(input int st);
        int row, col;
        logic [3:0] m;
        row  = (st - 1) / 5;
        col  = (st - 1) % 5;
        m[0] = row > 0;
        m[1] = row < 4;
        m[2] = col > 0;
        m[3] = col < 4;
        return m;
    endfunction

    function automatic int m_greedy(input int st);
        logic [3:0] leg;
        int maxv;
        leg  = m_legal(st);
        maxv = -1000000;
        for (int k = 0; k < 4; k++)
            if (leg[k] && int'($signed(qtab[k])) > maxv) maxv = int'($signed(qtab[k]));
        for (int k = 0; k < 4; k++)
            if (leg[k] && int'($signed(qtab[k])) == maxv) return k;
        return 0;
    endfunction

    function automatic int m_random(input int st, input logic [15:0] lf);
        logic [3:0] leg;
        int k;
        leg = m_legal(st);
        for (int s = 0; s < 4; s++) begin
            k = (int'(lf[9:8]) + s) % 4;
            if (leg[k]) return k;
        end
        return 0;
    endfunction

    task automatic run_request(input int st, input int eps, input logic [15:0] q0,
                               input logic [15:0] q1, input logic [15:0] q2,
                               input logic [15:0] q3, input bit hammer, input string name);
        logic [15:0] lf;
        logic [3:0]  exp_act;
        bit          exp_expl;
        int          choice;
        qtab[0] = q0; qtab[1] = q1; qtab[2] = q2; qtab[3] = q3;
        current_state = 6'(st);
        epsilon       = 8'(eps);
        en            = 1'b1;
        start         = 1'b1;
        @(posedge clk); #1;
        if (!hammer) start = 1'b0;
        current_state = 6'($urandom);
        if (st < 1 || st > 25) begin
            vectors++;
            if ({action_valid, q_rd_en, busy, bad_state, explored, next_action} !== {5'b10110, 4'b0000}) begin
                miscompares++;
                $display("FAIL %s illegal_done: got av/rd/busy/bad/exp/act=%b required 101100000", name,
                         {action_valid, q_rd_en, busy, bad_state, explored, next_action});
            end
            start = 1'b0;
            @(posedge clk); #1;
            vectors++;
            if ({action_valid, busy, bad_state} !== 3'b001) begin
                miscompares++;
                $display("FAIL %s illegal_idle: got av/busy/bad=%b required 001", name,
                         {action_valid, busy, bad_state});
            end
            $display("txn %s st=%0d bad_state=%b", name, st, bad_state);
            return;
        end
        for (int c = 1; c <= 4; c++) begin
            vectors++;
            if ({q_rd_en, action_valid, busy, q_addr} !== {3'b101, 6'(st), 2'(c - 1)}) begin
                miscompares++;
                $display("FAIL %s read%0d: got rd/av/busy=%b addr=%h required 101 addr=%h", name, c,
                         {q_rd_en, action_valid, busy}, q_addr, {6'(st), 2'(c - 1)});
            end
            if (hammer && c == 2) en = 1'b0;
            if (hammer && c == 4) en = 1'b1;
            @(posedge clk); #1;
        end
        vectors++;
        if ({q_rd_en, action_valid, busy} !== 3'b001) begin
            miscompares++;
            $display("FAIL %s drain: got rd/av/busy=%b required 001", name, {q_rd_en, action_valid, busy});
        end
        @(posedge clk); #1;
        lf = lfsr_m;
        vectors++;
        if ({q_rd_en, action_valid, busy} !== 3'b001) begin
            miscompares++;
            $display("FAIL %s decide: got rd/av/busy=%b required 001", name, {q_rd_en, action_valid, busy});
        end
        exp_expl = int'(lf[7:0]) < eps;
        choice   = exp_expl ? m_random(st, lf) : m_greedy(st);
        exp_act  = 4'(1 << choice);
        @(posedge clk); #1;
        start = 1'b0;
        vectors++;
        if ({action_valid, busy, bad_state, explored, next_action} !== {3'b110, exp_expl, exp_act}) begin
            miscompares++;
            $display("FAIL %s result: got av/busy/bad/exp/act=%b required %b", name,
                     {action_valid, busy, bad_state, explored, next_action}, {3'b110, exp_expl, exp_act});
        end
        @(posedge clk); #1;
        vectors++;
        if ({action_valid, busy, explored, next_action} !== {2'b00, exp_expl, exp_act}) begin
            miscompares++;
            $display("FAIL %s hold: got av/busy/exp/act=%b required %b", name,
                     {action_valid, busy, explored, next_action}, {2'b00, exp_expl, exp_act});
        end
        $display("txn %s st=%0d eps=%0d act=%b explored=%b", name, st, eps, next_action, explored);
    endtask

    task automatic test_reset();
        rst = 1'b1; en = 1'b0; start = 1'b0; epsilon = '0; current_state = '0;
        repeat (2) @(posedge clk);
        #1;
        vectors++;
        if ({q_rd_en, q_addr, next_action, action_valid, explored, bad_state, busy} !== 17'd0) begin
            miscompares++;
            $display("FAIL reset_state: got %h required 0",
                     {q_rd_en, q_addr, next_action, action_valid, explored, bad_state, busy});
        end
        rst = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_directed();
        run_request(13, 0, 16'd10, -16'sd5, 16'd40, 16'd40, 1'b0, "tie_left");
        run_request(1, 0, 16'd100, 16'd3, 16'd100, 16'd7, 1'b0, "corner_1");
        run_request(25, 0, -16'sd1, 16'd50, 16'd50, -16'sd2, 1'b0, "goal_25");
        run_request(21, 0, 16'd5, 16'd5, 16'd5, 16'd5, 1'b0, "all_tie_21");
    endtask

    task automatic test_illegal();
        run_request(0, 0, 16'd1, 16'd2, 16'd3, 16'd4, 1'b0, "bad_0");
        run_request(30, 200, 16'd1, 16'd2, 16'd3, 16'd4, 1'b0, "bad_30");
        run_request(26, 0, 16'd1, 16'd2, 16'd3, 16'd4, 1'b0, "bad_26");
    endtask

    task automatic test_back_to_back();
        run_request(8, 0, 16'd1, 16'd9, 16'd2, 16'd3, 1'b1, "busy_start");
        run_request(63, 0, 16'd0, 16'd0, 16'd0, 16'd0, 1'b0, "bad_63");
        run_request(9, 0, 16'd4, 16'd3, 16'd2, 16'd8, 1'b0, "after_bad");
    endtask

    task automatic test_explore();
        for (int i = 0; i < 200; i++)
            run_request(5, 255, 16'($urandom), 16'($urandom), 16'($urandom), 16'($urandom), 1'b0, "explore_5");
    endtask

    task automatic test_mixed();
        logic [15:0] qr [4];
        for (int i = 0; i < 80; i++) begin
            for (int k = 0; k < 4; k++)
                qr[k] = (i % 2 == 0) ? 16'($urandom) : 16'($urandom_range(0, 7)) - 16'd4;
            run_request(int'($urandom_range(0, 27)), int'($urandom_range(0, 255)),
                        qr[0], qr[1], qr[2], qr[3], 1'b0, "mixed");
        end
    endtask

    task automatic test_reset_mid();
        bit saw_valid;
        qtab[0] = 16'd1; qtab[1] = 16'd2; qtab[2] = 16'd3; qtab[3] = 16'd4;
        current_state = 6'd7; epsilon = 8'd0; en = 1'b1; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        #1;
        vectors++;
        if ({q_rd_en, q_addr, next_action, action_valid, explored, bad_state, busy} !== 17'd0) begin
            miscompares++;
            $display("FAIL reset_mid: got %h required 0",
                     {q_rd_en, q_addr, next_action, action_valid, explored, bad_state, busy});
        end
        @(posedge clk); #1;
        rst = 1'b0;
        saw_valid = 1'b0;
        for (int c = 0; c < 8; c++) begin
            @(posedge clk); #1;
            if (action_valid || busy) saw_valid = 1'b1;
        end
        vectors++;
        if (saw_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_abort: got activity=%b required 0", saw_valid);
        end
        $display("txn reset_mid aborted request");
        run_request(7, 0, 16'd1, 16'd2, 16'd3, 16'd4, 1'b0, "post_reset");
        run_request(19, 128, 16'd9, -16'sd9, 16'd0, 16'd9, 1'b0, "post_reset2");
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        q_rdata     = '0;
        for (int k = 0; k < 4; k++) qtab[k] = '0;
        test_reset();
        test_directed();
        test_illegal();
        test_back_to_back();
        test_explore();
        test_mixed();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
